// File: rtl/mult8x8_ctrl_pkg.sv
// rtl/mult8x8_ctrl_pkg.sv - shared state, nibble-select and shift codes for the 8x8 multiplier
package mult8x8_ctrl_pkg;

    localparam int NIB_W = 4;
    localparam int CNT_W = 2;
    localparam int ST_W  = 3;

    typedef enum logic [ST_W-1:0] {
        IDLE = 3'd0,
        LSB  = 3'd1,
        MID  = 3'd2,
        MSB  = 3'd3,
        DONE = 3'd4,
        ERR  = 3'd5
    } state_t;

    // {a_sel, b_sel}: 0 picks the low nibble, 1 the high nibble
    localparam logic [1:0] SEL_LO_LO = 2'b00;
    localparam logic [1:0] SEL_HI_LO = 2'b10;
    localparam logic [1:0] SEL_LO_HI = 2'b01;
    localparam logic [1:0] SEL_HI_HI = 2'b11;

    localparam logic [1:0] SHIFT_NONE = 2'b00;
    localparam logic [1:0] SHIFT_NIB  = 2'b01;
    localparam logic [1:0] SHIFT_BYTE = 2'b10;

endpackage

// File: rtl/mult8x8_ctrl_step_counter.sv
// rtl/mult8x8_ctrl_step_counter.sv - partial-product step counter with async and sync clear
// Ports: clk, aclr_n (async active-low clear), clr (sync clear, wins over en),
//        en (count up, wrapping), count (current step)
module mult_step_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         aclr_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/mult8x8_ctrl.sv
// rtl/mult8x8_ctrl.sv - sequencer stepping the 4x4 multiplier/shifter/accumulator datapath
// Optional feature macro: MULT_ERR_EN (start while busy -> ERR state, err output)
// Ports: clk, aclr_n (async active-low reset), start (level request),
//        input_sel {a_sel,b_sel}, shift_sel, acc_en, acc_load, done, busy, err,
//        state_out (state code), count_out (step count)
module mult8x8_ctrl
    import mult8x8_ctrl_pkg::*;
#(
    parameter int P_NIB_W = NIB_W,
    parameter int P_CNT_W = CNT_W,
    parameter int P_ST_W  = ST_W
) (
    input  logic               clk,
    input  logic               aclr_n,
    input  logic               start,
    output logic [1:0]         input_sel,
    output logic [1:0]         shift_sel,
    output logic               acc_en,
    output logic               acc_load,
    output logic               done,
    output logic               busy,
    output logic               err,
    output logic [P_ST_W-1:0]  state_out,
    output logic [P_CNT_W-1:0] count_out
);

    state_t             state;
    state_t             state_next;
    logic               cnt_en;
    logic               cnt_clr;
    logic [P_CNT_W-1:0] count;

    mult_step_counter #(.W(P_CNT_W)) u_cnt (
        .clk    (clk),
        .aclr_n (aclr_n),
        .clr    (cnt_clr),
        .en     (cnt_en),
        .count  (count)
    );

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        input_sel  = SEL_LO_LO;
        shift_sel  = SHIFT_NONE;
        acc_en     = 1'b0;
        acc_load   = 1'b0;
        done       = 1'b0;
        busy       = 1'b0;
        err        = 1'b0;
        cnt_en     = 1'b0;
        cnt_clr    = 1'b0;

        case (state)
            IDLE: begin
                cnt_clr = 1'b1;
                if (start) state_next = LSB;
            end
            LSB: begin
                busy       = 1'b1;
                acc_en     = 1'b1;
                acc_load   = 1'b1;
                input_sel  = SEL_LO_LO;
                shift_sel  = SHIFT_NONE;
                cnt_en     = 1'b1;
                state_next = MID;
            end
            MID: begin
                // Two cross terms share the same shift; count picks which one.
                busy      = 1'b1;
                acc_en    = 1'b1;
                shift_sel = SHIFT_NIB;
                cnt_en    = 1'b1;
                if (count == P_CNT_W'(1)) begin
                    input_sel = SEL_HI_LO;
                end else begin
                    input_sel  = SEL_LO_HI;
                    state_next = MSB;
                end
            end
            MSB: begin
                busy       = 1'b1;
                acc_en     = 1'b1;
                input_sel  = SEL_HI_HI;
                shift_sel  = SHIFT_BYTE;
                cnt_en     = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                cnt_clr    = 1'b1;
                state_next = start ? LSB : IDLE;
            end
`ifdef MULT_ERR_EN
            ERR: begin
                err        = 1'b1;
                cnt_clr    = 1'b1;
                state_next = start ? ERR : IDLE;
            end
`endif
            default: begin
                cnt_clr    = 1'b1;
                state_next = IDLE;
            end
        endcase

`ifdef MULT_ERR_EN
        // A new request mid-sequence is a protocol violation; clear the
        // counter on the way in so ERR is entered with count 0.
        if (busy && start) begin
            state_next = ERR;
            cnt_en     = 1'b0;
            cnt_clr    = 1'b1;
        end
`endif
    end

    assign state_out = P_ST_W'(state);
    assign count_out = count;

endmodule

// File: tb/tb_mult8x8_ctrl.sv
// tb/tb_mult8x8_ctrl.sv - directed self-checking bench for mult8x8_ctrl with a behavioural datapath
module tb_mult8x8_ctrl;

    logic        clk = 1'b0;
    logic        aclr_n;
    logic        start;
    logic [1:0]  input_sel;
    logic [1:0]  shift_sel;
    logic        acc_en;
    logic        acc_load;
    logic        done;
    logic        busy;
    logic        err;
    logic [2:0]  state_out;
    logic [1:0]  count_out;

    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] acc;
    logic [7:0]  pp;
    logic [15:0] shifted;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mult8x8_ctrl dut (
        .clk       (clk),
        .aclr_n    (aclr_n),
        .start     (start),
        .input_sel (input_sel),
        .shift_sel (shift_sel),
        .acc_en    (acc_en),
        .acc_load  (acc_load),
        .done      (done),
        .busy      (busy),
        .err       (err),
        .state_out (state_out),
        .count_out (count_out)
    );

    // Datapath: one 4x4 multiplier, shifter, accumulator
    always_comb begin
        pp = (input_sel[1] ? a[7:4] : a[3:0]) * (input_sel[0] ? b[7:4] : b[3:0]);
        case (shift_sel)
            2'b01:   shifted = {8'h00, pp} << 4;
            2'b10:   shifted = {8'h00, pp} << 8;
            default: shifted = {8'h00, pp};
        endcase
    end

    always @(posedge clk) begin
        if (acc_en) acc <= acc_load ? shifted : acc + shifted;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One-cycle start pulse; checks done arrives on the 5th edge and the product.
    task automatic run_mult(input string tag, input logic [7:0] av, input logic [7:0] bv,
                            input logic [15:0] exp);
        int edges;
        a = av;
        b = bv;
        start = 1'b1;
        tick();
        start = 1'b0;
        edges = 1;
        while (!done && edges < 12) begin
            tick();
            edges++;
        end
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_lat"}, edges, 32'd5);
        chk({tag, "_prod"}, {16'd0, acc}, {16'd0, exp});
        tick();
        chk({tag, "_idle"}, {29'd0, state_out}, 32'd0);
    endtask

    initial begin
        int edges;
        aclr_n = 1'b0;
        start  = 1'b1;
        a      = 8'h00;
        b      = 8'h00;

        // 1. reset held with start asserted
        tick();
        tick();
        chk("rst_state", {29'd0, state_out}, 32'd0);
        chk("rst_count", {30'd0, count_out}, 32'd0);
        chk("rst_ctl", {28'd0, done, busy, acc_en, err}, 32'd0);
        aclr_n = 1'b1;
        tick();
        chk("rel_lsb", {29'd0, state_out}, 32'd1);
        start = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("rel_back_idle", {29'd0, state_out}, 32'd0);

        // 2. single run, step by step
        a = 8'h21;
        b = 8'h43;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("s1", {22'd0, state_out, count_out, input_sel, shift_sel, acc_en, acc_load, busy},
            {22'd0, 3'd1, 2'd0, 2'b00, 2'b00, 1'b1, 1'b1, 1'b1});
        tick();
        chk("s2", {22'd0, state_out, count_out, input_sel, shift_sel, acc_en, acc_load, busy},
            {22'd0, 3'd2, 2'd1, 2'b10, 2'b01, 1'b1, 1'b0, 1'b1});
        tick();
        chk("s3", {22'd0, state_out, count_out, input_sel, shift_sel, acc_en, acc_load, busy},
            {22'd0, 3'd2, 2'd2, 2'b01, 2'b01, 1'b1, 1'b0, 1'b1});
        tick();
        chk("s4", {22'd0, state_out, count_out, input_sel, shift_sel, acc_en, acc_load, busy},
            {22'd0, 3'd3, 2'd3, 2'b11, 2'b10, 1'b1, 1'b0, 1'b1});
        tick();
        chk("s5", {25'd0, state_out, count_out, done, busy},
            {25'd0, 3'd4, 2'd0, 1'b1, 1'b0});
        chk("s5_acc_en", {31'd0, acc_en}, 32'd0);
        chk("s5_prod", {16'd0, acc}, 32'h0000_08A3);
        tick();
        chk("s6", {29'd0, state_out, done}, {29'd0, 3'd0, 1'b0});

        // 3. products through the datapath
        run_mult("ff_ff", 8'hFF, 8'hFF, 16'hFE01);
        run_mult("00_a5", 8'h00, 8'hA5, 16'h0000);
        run_mult("0c_30", 8'h0C, 8'h30, 16'h0240);

`ifndef MULT_ERR_EN
        // 4. back-to-back with start held
        a = 8'h12;
        b = 8'h34;
        start = 1'b1;
        edges = 0;
        while (!done && edges < 12) begin
            tick();
            edges++;
        end
        chk("b2b_done1", {31'd0, done}, 32'd1);
        chk("b2b_prod1", {16'd0, acc}, 32'h0000_03A8);
        a = 8'h0F;
        b = 8'h0F;
        tick();
        chk("b2b_no_idle", {29'd0, state_out}, 32'd1);
        edges = 1;
        while (!done && edges < 12) begin
            tick();
            edges++;
        end
        chk("b2b_gap", edges, 32'd5);
        chk("b2b_prod2", {16'd0, acc}, 32'h0000_00E1);
        start = 1'b0;
        tick();
        chk("b2b_idle", {29'd0, state_out}, 32'd0);
`endif

        // 5. abort in MID count 2
        a = 8'h77;
        b = 8'h88;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("abort_pre", {27'd0, state_out, count_out}, {27'd0, 3'd2, 2'd2});
        aclr_n = 1'b0;
        #1;
        chk("abort_state", {29'd0, state_out}, 32'd0);
        chk("abort_count", {30'd0, count_out}, 32'd0);
        tick();
        aclr_n = 1'b1;
        run_mult("post_abort", 8'h0C, 8'h30, 16'h0240);

        // 6. start re-asserted during MID
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
`ifdef MULT_ERR_EN
        chk("err_enter", {26'd0, state_out, err, acc_en, count_out}, {26'd0, 3'd5, 1'b1, 1'b0, 2'd0});
        tick();
        tick();
        chk("err_hold", {28'd0, state_out, err}, {28'd0, 3'd5, 1'b1});
        start = 1'b0;
        tick();
        chk("err_exit", {28'd0, state_out, err}, {28'd0, 3'd0, 1'b0});
`else
        chk("noerr_mid", {28'd0, state_out, err}, {28'd0, 3'd2, 1'b0});
        tick();
        tick();
        chk("noerr_done", {27'd0, state_out, done, err}, {27'd0, 3'd4, 1'b1, 1'b0});
        start = 1'b0;
        tick();
        chk("noerr_idle", {28'd0, state_out, err}, {28'd0, 3'd0, 1'b0});
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
